// File: rtl/dpbram_port_arb_pkg.sv
// -----------------------------------------------------------------------------
// dpbram_port_arb_pkg
//   Shared definitions for the dpbram port arbiter: FSM state encodings,
//   requester ids and the beat-counter width helper.
// -----------------------------------------------------------------------------
package dpbram_port_arb_pkg;

   // Arbiter ownership states (legacy-compatible 2-bit encoding)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   // Requester ids, also used as the rr_ptr / read-return tag encoding
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Beat counter width; a 1-beat bound still needs a 1-bit counter
   function automatic int cnt_width(input int max_burst);
      return (max_burst > 1) ? $clog2(max_burst) : 1;
   endfunction

endpackage

// File: rtl/dpbram_port_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin pick, purely combinational.
//   req  in  2  request vector (bit 0 = m0, bit 1 = m1)
//   ptr  in  1  preferred requester when both request
//   gnt  out 2  one-hot winner, 0 when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2
   import dpbram_port_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (ptr == M1) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dpbram_port_arb.sv
// -----------------------------------------------------------------------------
// dpbram_port_arb
//   Round-robin, burst-locking arbiter sharing one dpbram port between m0
//   (AXI slave side) and m1 (conv engine). Whole bursts are granted; a burst
//   is forcibly released after MAX_BURST beats. Read data (1-cycle latency
//   from the dpbram) is returned to the requester that issued the read.
//
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/we/addr/wdata/last_mX requester mX beat
//   o_gnt_mX                    mX owns the port (beat when i_req_mX too)
//   o_rvalid_mX, o_rdata        read return, o_rdata shared by both
//   o_w_en/o_w_addr/o_w_data    dpbram write port
//   o_r_en/o_r_addr, i_r_data   dpbram read port
// -----------------------------------------------------------------------------
module dpbram_port_arb
   import dpbram_port_arb_pkg::*;
#(
   parameter int ADDR_BW   = 10,
   parameter int DATA_BW   = 32,
   parameter int MAX_BURST = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_req_m0,
   input  logic               i_we_m0,
   input  logic [ADDR_BW-1:0] i_addr_m0,
   input  logic [DATA_BW-1:0] i_wdata_m0,
   input  logic               i_last_m0,
   input  logic               i_req_m1,
   input  logic               i_we_m1,
   input  logic [ADDR_BW-1:0] i_addr_m1,
   input  logic [DATA_BW-1:0] i_wdata_m1,
   input  logic               i_last_m1,
   output logic               o_gnt_m0,
   output logic               o_gnt_m1,
   output logic               o_rvalid_m0,
   output logic               o_rvalid_m1,
   output logic [DATA_BW-1:0] o_rdata,
   output logic               o_w_en,
   output logic [ADDR_BW-1:0] o_w_addr,
   output logic [DATA_BW-1:0] o_w_data,
   output logic               o_r_en,
   output logic [ADDR_BW-1:0] o_r_addr,
   input  logic [DATA_BW-1:0] i_r_data
);

   localparam int               CNT_W    = cnt_width(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   logic [1:0]         state, state_nxt;
   logic               rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
   logic               rd_pend, rd_id;
   logic [1:0]         pick;

   // Owner-side view of the requesters (all zero while IDLE)
   logic               own_req, own_we, own_last, own_id, oth_req;
   logic [ADDR_BW-1:0] own_addr;
   logic [DATA_BW-1:0] own_wdata;
   logic               beat, rel;

   rr_arb2 u_rr_arb2 (
      .req ({i_req_m1, i_req_m0}),
      .ptr (rr_ptr),
      .gnt (pick)
   );

   assign o_gnt_m0 = (state == ST_OWN0);
   assign o_gnt_m1 = (state == ST_OWN1);

   always_comb begin
      own_req   = 1'b0;
      own_we    = 1'b0;
      own_last  = 1'b0;
      own_id    = M0;
      oth_req   = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      case (state)
         ST_OWN0: begin
            own_req   = i_req_m0;
            own_we    = i_we_m0;
            own_last  = i_last_m0;
            own_id    = M0;
            oth_req   = i_req_m1;
            own_addr  = i_addr_m0;
            own_wdata = i_wdata_m0;
         end
         ST_OWN1: begin
            own_req   = i_req_m1;
            own_we    = i_we_m1;
            own_last  = i_last_m1;
            own_id    = M1;
            oth_req   = i_req_m0;
            own_addr  = i_addr_m1;
            own_wdata = i_wdata_m1;
         end
         default: ;
      endcase
   end

   assign beat = own_req;   // own_req is only non-zero while owning
   assign rel  = beat & (own_last | (beat_cnt == CNT_LAST));

   assign o_w_en   = beat & own_we;
   assign o_r_en   = beat & ~own_we;
   assign o_w_addr = own_addr;
   assign o_r_addr = own_addr;
   assign o_w_data = own_wdata;

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      beat_cnt_nxt = beat_cnt;
      case (state)
         ST_IDLE: begin
            if (|pick) begin
               state_nxt    = pick[1] ? ST_OWN1 : ST_OWN0;
               beat_cnt_nxt = '0;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (rel) begin
               rr_ptr_nxt   = ~own_id;
               beat_cnt_nxt = '0;
               if (oth_req) begin
                  state_nxt = (own_id == M0) ? ST_OWN1 : ST_OWN0;
               end else if (!own_last) begin
                  // Forced release: the owner's burst still has beats pending,
                  // so it starts a fresh burst without a bubble. After a real
                  // last beat its next request is unknown, so fall back to IDLE.
                  state_nxt = state;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (beat) begin
               beat_cnt_nxt = beat_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rr_ptr   <= M0;
         beat_cnt <= '0;
         rd_pend  <= 1'b0;
         rd_id    <= M0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
         rd_pend  <= o_r_en;
         rd_id    <= own_id;
      end
   end

   assign o_rvalid_m0 = rd_pend & (rd_id == M0);
   assign o_rvalid_m1 = rd_pend & (rd_id == M1);
   // Gated so the shared bus reads 0 when no return is pending
   assign o_rdata     = rd_pend ? i_r_data : '0;

endmodule
